// File: rtl/lighting_pkg.sv
// rtl/lighting_pkg.sv - shared types, constants and helpers for the lighting scheduler
package lighting_pkg;

  typedef enum logic [1:0] {IDLE, SETTLE, RAMP} state_t;

  localparam int SLOT_MAX = 11;
  localparam int CODE_W   = 4;
  localparam int STATE_W  = 16;

  // Thermometer code: bit i set when i < n
  function automatic logic [STATE_W-1:0] thermo(input logic [CODE_W-1:0] n);
    logic [STATE_W-1:0] t;
    t = '0;
    for (int i = 0; i < STATE_W; i++) t[i] = (i < int'(n));
    return t;
  endfunction

endpackage

// File: rtl/lighting_scheduler_ramp_channel.sv
// rtl/lighting_scheduler_ramp_channel.sv - one ramped output channel stepping one unit toward its target
module ramp_channel
  import lighting_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              step,
  input  logic [CODE_W-1:0] target_in,
  output logic [CODE_W-1:0] value,
  output logic              at_target,
  output logic              load_match
);

  logic [CODE_W-1:0] tgt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value <= '0;
      tgt   <= '0;
    end else begin
      if (load) tgt <= target_in;
      if (step && (value != tgt)) begin
        if (value < tgt) value <= value + 4'd1;
        else             value <= value - 4'd1;
      end
    end
  end

  assign at_target  = (value == tgt);
  // Compared against the live datapath target so SETTLE can decide before tgt is loaded
  assign load_match = (value == target_in);

endmodule

// File: rtl/lighting_scheduler.sv
// rtl/lighting_scheduler.sv - slot timer, request register and ramp sequencing for the lighting datapath
module lighting_scheduler
  import lighting_pkg::*;
#(
  parameter int TICKS_PER_SLOT = 120,
  parameter int RAMP_DIV       = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               tick,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [CODE_W-1:0]  req_ulight,
  input  logic [CODE_W-1:0]  tgt_lightnum,
  input  logic [CODE_W-1:0]  tgt_wshade,
  output logic [CODE_W-1:0]  tcode,
  output logic [CODE_W-1:0]  ulight,
  output logic [CODE_W-1:0]  lightnum,
  output logic [CODE_W-1:0]  wshade,
  output logic [STATE_W-1:0] lightstate,
  output logic               busy,
  output logic               done
);

  localparam logic [11:0] TICK_LAST = 12'(TICKS_PER_SLOT - 1);
  localparam logic [7:0]  DIV_LAST  = 8'(RAMP_DIV - 1);
  localparam logic [CODE_W-1:0] SLOT_LAST = CODE_W'(SLOT_MAX);

  state_t      state;
  logic        refresh;
  logic [11:0] tick_cnt;
  logic [7:0]  div_cnt;

  logic accept, slot_wrap, pending, both_at, step_en, load_en;
  logic lamp_at, shade_at, lamp_match, shade_match;

  assign req_ready = (state != SETTLE);
  assign accept    = req_valid && req_ready;
  assign slot_wrap = tick && (tick_cnt == TICK_LAST);
  // A request or slot change arriving this cycle counts as already pending
  assign pending   = refresh || accept || slot_wrap;
  assign both_at   = lamp_at && shade_at;
  assign load_en   = (state == SETTLE);
  assign step_en   = (state == RAMP) && !pending && !both_at && (div_cnt == DIV_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt <= '0;
      tcode    <= '0;
    end else if (tick) begin
      if (slot_wrap) begin
        tick_cnt <= '0;
        tcode    <= (tcode == SLOT_LAST) ? '0 : tcode + 4'd1;
      end else begin
        tick_cnt <= tick_cnt + 12'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      ulight <= '0;
    else if (accept) ulight <= req_ulight;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      refresh <= 1'b1;
      div_cnt <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept || slot_wrap)  refresh <= 1'b1;
      else if (state == SETTLE) refresh <= 1'b0;
      case (state)
        IDLE: begin
          if (pending) begin
            state <= SETTLE;
            busy  <= 1'b1;
          end
        end
        SETTLE: begin
          div_cnt <= '0;
          if (lamp_match && shade_match) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            state <= RAMP;
          end
        end
        RAMP: begin
          if (pending) begin
            state   <= SETTLE;
            div_cnt <= '0;
          end else if (both_at) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
          end else begin
            div_cnt <= div_cnt + 8'd1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  ramp_channel u_lamp (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (load_en),
    .step       (step_en),
    .target_in  (tgt_lightnum),
    .value      (lightnum),
    .at_target  (lamp_at),
    .load_match (lamp_match)
  );

  ramp_channel u_shade (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (load_en),
    .step       (step_en),
    .target_in  (tgt_wshade),
    .value      (wshade),
    .at_target  (shade_at),
    .load_match (shade_match)
  );

  assign lightstate = thermo(lightnum);

endmodule

// File: tb/tb_lighting_scheduler.sv
// tb/tb_lighting_scheduler.sv - randomized scoreboard bench for lighting_scheduler
module tb_lighting_scheduler;

  localparam int TPS = 2;
  localparam int RD  = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        tick = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [3:0]  req_ulight = 4'd0;
  logic [3:0]  tgt_lightnum, tgt_wshade;
  logic [3:0]  tcode, ulight, lightnum, wshade;
  logic [15:0] lightstate;
  logic        busy, done;

  logic [3:0] lut_ln [16][16];
  logic [3:0] lut_ws [16][16];

  assign tgt_lightnum = lut_ln[tcode][ulight];
  assign tgt_wshade   = lut_ws[tcode][ulight];

  lighting_scheduler #(.TICKS_PER_SLOT(TPS), .RAMP_DIV(RD)) dut (
    .clk(clk), .rst_n(rst_n), .tick(tick), .req_valid(req_valid), .req_ready(req_ready),
    .req_ulight(req_ulight), .tgt_lightnum(tgt_lightnum), .tgt_wshade(tgt_wshade),
    .tcode(tcode), .ulight(ulight), .lightnum(lightnum), .wshade(wshade),
    .lightstate(lightstate), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct { int tc; int ul; int ln; int ws; } exp_t;
  exp_t q[$];
  exp_t e;
  int checks = 0;
  int failures = 0;
  int m_ticks = 0;
  int m_ul = 0;
  int prev_ln = 0;

  function automatic int m_tcode();
    return (m_ticks / TPS) % 12;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_exp();
    int tc;
    tc = m_tcode();
    q.push_back('{tc, m_ul, int'(lut_ln[tc][m_ul]), int'(lut_ws[tc][m_ul])});
  endtask

  // Monitor: each done pulse is checked against the oldest expected settled state
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_ln = 0;
    end else begin
      if (int'(lightnum) != prev_ln) begin
        chk("ramp_step", (int'(lightnum) > prev_ln) ? int'(lightnum) - prev_ln : prev_ln - int'(lightnum), 1);
        prev_ln = int'(lightnum);
      end
      if (done) begin
        if (q.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          e = q.pop_front();
          chk("done_tcode", int'(tcode), e.tc);
          chk("done_ulight", int'(ulight), e.ul);
          chk("done_lightnum", int'(lightnum), e.ln);
          chk("done_wshade", int'(wshade), e.ws);
          chk("done_lightstate", int'(lightstate), (1 << e.ln) - 1);
          chk("done_busy", int'(busy), 0);
        end
      end
    end
  end

  task automatic wait_done();
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (q.size() == 0) break;
    end
    if (q.size() != 0) begin
      chk("done_timeout", q.size(), 0);
      q.delete();
    end
  endtask

  task automatic send_req(input int u, input bit do_push);
    req_valid  = 1'b1;
    req_ulight = 4'(u);
    chk("req_ready_pre", int'(req_ready), 1);
    m_ul = u;
    if (do_push) push_exp();
    @(negedge clk);
    req_valid = 1'b0;
    chk("ulight_next", int'(ulight), u);
    chk("req_ready_settle", int'(req_ready), 0);
    chk("busy_settle", int'(busy), 1);
    @(negedge clk);
    chk("req_ready_after", int'(req_ready), 1);
  endtask

  task automatic prep_ticks();
    while ((m_ticks % TPS) != TPS - 1) begin
      tick = 1'b1;
      @(negedge clk);
      tick = 1'b0;
      m_ticks++;
    end
  endtask

  task automatic op_tick();
    prep_ticks();
    tick = 1'b1;
    m_ticks++;
    push_exp();
    @(negedge clk);
    tick = 1'b0;
    chk("tcode_step", int'(tcode), m_tcode());
    wait_done();
  endtask

  task automatic op_same(input int u);
    prep_ticks();
    tick       = 1'b1;
    req_valid  = 1'b1;
    req_ulight = 4'(u);
    m_ticks++;
    m_ul = u;
    push_exp();
    @(negedge clk);
    tick      = 1'b0;
    req_valid = 1'b0;
    chk("same_tcode", int'(tcode), m_tcode());
    chk("same_ulight", int'(ulight), u);
    wait_done();
  endtask

  function automatic int find_req(input int min_dln);
    int tc, cl, cw, d;
    tc = m_tcode();
    cl = int'(lut_ln[tc][m_ul]);
    cw = int'(lut_ws[tc][m_ul]);
    for (int k = 0; k < 16; k++) begin
      int u;
      u = (k + int'($urandom_range(0, 15))) % 16;
      d = int'(lut_ln[tc][u]) - cl;
      if (d < 0) d = -d;
      if (min_dln > 0 && d >= min_dln) return u;
      if (min_dln == 0 && (d != 0 || int'(lut_ws[tc][u]) != cw)) return u;
    end
    return -1;
  endfunction

  initial begin
    int op, u, u2;
    for (int t = 0; t < 16; t++)
      for (int v = 0; v < 16; v++) begin
        lut_ln[t][v] = 4'($urandom_range(0, 15));
        lut_ws[t][v] = 4'($urandom_range(0, 15));
      end
    lut_ln[0][0] = 4'd4;
    lut_ws[0][0] = 4'd2;

    repeat (2) @(negedge clk);
    chk("rst_tcode", int'(tcode), 0);
    chk("rst_ulight", int'(ulight), 0);
    chk("rst_lightnum", int'(lightnum), 0);
    chk("rst_wshade", int'(wshade), 0);
    chk("rst_lightstate", int'(lightstate), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_req_ready", int'(req_ready), 1);
    push_exp();
    rst_n = 1'b1;
    @(negedge clk);
    chk("first_settle_busy", int'(busy), 1);
    wait_done();

    for (int s = 0; s < 12; s++) op_tick();
    chk("tcode_wrapped", int'(tcode), 0);

    for (int it = 0; it < 40; it++) begin
      op = int'($urandom_range(0, 3));
      u  = int'($urandom_range(0, 15));
      case (op)
        0: begin send_req(u, 1'b1); wait_done(); end
        1: op_tick();
        2: op_same(u);
        default: begin
          u = find_req(0);
          if (u < 0) begin
            op_tick();
          end else begin
            send_req(u, 1'b0);
            u2 = int'($urandom_range(0, 15));
            send_req(u2, 1'b1);
            wait_done();
          end
        end
      endcase
    end

    u = find_req(2);
    if (u >= 0) begin
      send_req(u, 1'b0);
      repeat (2) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("async_lightnum", int'(lightnum), 0);
      chk("async_wshade", int'(wshade), 0);
      chk("async_lightstate", int'(lightstate), 0);
      chk("async_tcode", int'(tcode), 0);
      chk("async_busy", int'(busy), 0);
      q.delete();
      m_ticks = 0;
      m_ul = 0;
      repeat (2) @(negedge clk);
      push_exp();
      rst_n = 1'b1;
      @(negedge clk);
      chk("restart_busy", int'(busy), 1);
      wait_done();
    end

    repeat (5) @(negedge clk);
    chk("final_queue_empty", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lighting_scheduler.md
# lighting_scheduler

Sequencing controller for the smart-home lighting datapath. It keeps the time-of-day slot and drives it to the datapath as `tcode`, and registers user light-mode requests into the datapath's `ulight` through a valid/ready handshake. It latches the datapath's combinational targets for lamp count and window shade, then ramps the visible lamp count and shade level toward those targets one unit at a time so changes fade in rather than jump. It sits between the house timer and user panel on one side and the lighting datapath plus the lamp/shade drivers on the other.

## Interface
- `TICKS_PER_SLOT`, default 120: `tick` pulses per time slot (1..4095).
- `RAMP_DIV`, default 16: clock cycles per ramp step (1..255).
- `clk`, in, 1: system clock, rising edge.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `tick`, in, 1: one-cycle time-base pulse.
- `req_valid`, in, 1: user mode request valid.
- `req_ready`, out, 1: request accepted when high together with `req_valid`.
- `req_ulight`, in, 4: requested light degree mode.
- `tgt_lightnum`, in, 4: datapath lamp-count target; combinational from `tcode`/`ulight`.
- `tgt_wshade`, in, 4: datapath shade target; combinational.
- `tcode`, out, 4: current slot 0..11, to datapath.
- `ulight`, out, 4: registered user mode, to datapath.
- `lightnum`, out, 4: ramped active-lamp count.
- `wshade`, out, 4: ramped shade level.
- `lightstate`, out, 16: thermometer of `lightnum`; bit i = (i < `lightnum`).
- `busy`, out, 1: high in SETTLE or RAMP.
- `done`, out, 1: one-cycle pulse when outputs reach the targets.

## Operation
- Slot timer: a 12-bit tick counter counts `tick` pulses. At the `TICKS_PER_SLOT`-th tick it clears and `tcode` increments; 11 wraps to 0. A slot change raises the internal `refresh` flag.
- Request handshake: `req_ready` = (state != SETTLE). On accept, `ulight` <= `req_ulight` and `refresh` is set. Back-to-back accepts are legal; the last accepted value wins.
- FSM states: IDLE, SETTLE, RAMP.
  - IDLE, with `refresh` set: go to SETTLE.
  - SETTLE lasts one cycle. It clears `refresh` and latches `tgt_lightnum`/`tgt_wshade` into the target registers. If both targets equal the current outputs, go to IDLE and pulse `done`; otherwise go to RAMP.
  - RAMP: the divider counts 0..`RAMP_DIV`-1. At the terminal count, each channel not at its target steps ±1 toward it and the divider clears. The channels are independent.
    - When both channels match their targets, go to IDLE with a `done` pulse.
    - If `refresh` is set, go to SETTLE without a step on that cycle. Current values are kept and the new ramp starts from them, with no jump.
- A request and a slot change in the same cycle are both applied. They produce a single SETTLE.
- A `tick` during SETTLE or RAMP is still counted.
- `refresh` is set by reset, so the first post-reset cycle enters SETTLE and ramps up from 0.
- Width rules: all 4-bit quantities are unsigned. Steps never overflow because they move toward a 4-bit target. `lightstate` uses only values 0..15; lightnum=15 sets bits 0..14.

## Timing
- Reset values: state IDLE, `refresh` 1, `tcode` 0, `ulight` 0, `lightnum` 0, `wshade` 0, `lightstate` 0, `busy` 0, `done` 0, divider 0, tick counter 0. `req_ready` is 1 in the reset state.
- Accept at cycle N:
  - `ulight` valid at N+1.
  - SETTLE at N+1, with targets sampled at the end of N+1.
  - RAMP from N+2.
  - First step visible at N+2+`RAMP_DIV`.
- Full ramp latency: max(|Δlightnum|, |Δwshade|) × `RAMP_DIV` cycles after RAMP entry. `done` is asserted in the cycle the FSM returns to IDLE.
- Reset asserted mid-operation forces all reset values immediately (asynchronously). Any in-flight request is dropped.

## Structure
- Package `lighting_pkg`:
  - State enum {IDLE, SETTLE, RAMP}.
  - `SLOT_MAX` = 11.
  - Widths `CODE_W` = 4, `STATE_W` = 16.
- Sub-module `ramp_channel`: a 4-bit current register, a load-target input, a step-enable input, and an at-target output. It is instantiated twice, for lamps and shade. The divider and FSM stay in the top level.

## Test plan
- Reset, datapath targets 4/2, RAMP_DIV=2: all outputs 0 during reset → SETTLE in the first cycle after release → lightnum reaches 4 eight cycles after RAMP entry, wshade reaches 2 after four; one `done` pulse; lightstate=0x000F.
- Request ulight=5 with targets 6/3 from current 0/0, RAMP_DIV=4: req_ready=1, ulight=5 next cycle; lightnum increments every 4 cycles to 6 (24 cycles); wshade holds 3 from cycle 12.
- TICKS_PER_SLOT=2, 24 ticks: tcode steps 0..11 and wraps to 0; one SETTLE per change.
- Request during a ramp at lightnum=3 with the new target 1: req_ready=1, SETTLE, then steps 3→2→1 with no jump; req_ready=0 during the SETTLE cycle only.
- Request and slot boundary in the same cycle: tcode and ulight both update; exactly one SETTLE; a single `done`.
- rst_n low mid-ramp at lightnum=5: lightnum, wshade, lightstate and tcode go to 0 asynchronously; after release the block restarts with SETTLE.
